// File: rtl/eca_pkg.sv
// rtl/eca_pkg.sv - shared constants and state type for the cellular-automaton engine
package eca_pkg;
    localparam logic [1:0] BND_ZERO = 2'd0;
    localparam logic [1:0] BND_ONE  = 2'd1;
    localparam logic [1:0] BND_WRAP = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/eca_if.sv
// rtl/eca_if.sv - generation output stream with valid/ready backpressure
interface eca_if #(
    parameter int LEN = 512
);
    logic [LEN-1:0] q;
    logic           q_valid;
    logic           q_ready;

    modport master (
        output q,
        output q_valid,
        input  q_ready
    );

    modport slave (
        input  q,
        input  q_valid,
        output q_ready
    );
endinterface

// File: rtl/eca_next_gen.sv
// rtl/eca_next_gen.sv - combinational one-step update of an elementary cellular automaton
module eca_next_gen
    import eca_pkg::*;
#(
    parameter int LEN = 512
) (
    input  logic [LEN-1:0] q,
    input  logic [7:0]     rule,
    input  logic [1:0]     bnd_mode,
    output logic [LEN-1:0] nxt
);
    logic           bnd_l;
    logic           bnd_r;
    logic [LEN+1:0] ext;

    always_comb begin
        bnd_l = 1'b0;
        bnd_r = 1'b0;
        case (bnd_mode)
            BND_ONE: begin
                bnd_l = 1'b1;
                bnd_r = 1'b1;
            end
            BND_WRAP: begin
                bnd_l = q[0];
                bnd_r = q[LEN-1];
            end
            default: begin
                bnd_l = 1'b0;
                bnd_r = 1'b0;
            end
        endcase
        // ext[i+2:i] is the {left, centre, right} neighbourhood of cell i
        ext = {bnd_l, q, bnd_r};
        nxt = '0;
        for (int i = 0; i < LEN; i++) begin
            nxt[i] = rule[ext[i +: 3]];
        end
    end
endmodule

// File: rtl/eca_engine.sv
// rtl/eca_engine.sv - runs N generations of a selectable ECA rule and streams each one out
module eca_engine
    import eca_pkg::*;
#(
    parameter int LEN = 512,
    parameter int GW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [LEN-1:0] data,
    input  logic [7:0]     rule,
    input  logic [1:0]     bnd_mode,
    input  logic           start,
    input  logic [GW-1:0]  gens,
    input  logic           abort,
    eca_if.master          out_if,
    output logic           busy,
    output logic           done,
    output logic [GW-1:0]  gen_count
);
    state_e         state_q, state_d;
    logic [LEN-1:0] q_q, q_d;
    logic [GW-1:0]  gen_q, gen_d;
    logic [GW-1:0]  tgt_q, tgt_d;
    logic [7:0]     rule_q, rule_d;
    logic [1:0]     mode_q, mode_d;
    logic           done_q, done_d;
    logic [LEN-1:0] nxt;
    logic [7:0]     rule_eff;
    logic [1:0]     mode_eff;

    // The first generation is computed in the start cycle, before the latch settles
    assign rule_eff = (state_q == IDLE) ? rule : rule_q;
    assign mode_eff = (state_q == IDLE) ? bnd_mode : mode_q;

    eca_next_gen #(.LEN(LEN)) u_next_gen (
        .q        (q_q),
        .rule     (rule_eff),
        .bnd_mode (mode_eff),
        .nxt      (nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            gen_q   <= '0;
            tgt_q   <= '0;
            rule_q  <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            gen_q   <= gen_d;
            tgt_q   <= tgt_d;
            rule_q  <= rule_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        gen_d   = gen_q;
        tgt_d   = tgt_q;
        rule_d  = rule_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d   = data;
                    gen_d = '0;
                end else if (start) begin
                    if (gens == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rule_d  = rule;
                        mode_d  = bnd_mode;
                        tgt_d   = gens;
                        q_d     = nxt;
                        gen_d   = GW'(1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_if.q_ready) begin
                    if (gen_q == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        q_d   = nxt;
                        gen_d = gen_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_if.q       = q_q;
    assign out_if.q_valid = (state_q == HOLD);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign gen_count      = gen_q;
endmodule

// File: tb/tb_eca_engine.sv
// tb/tb_eca_engine.sv - directed-vector bench for eca_engine at LEN=8
module tb_eca_engine;
    localparam int LEN = 8;
    localparam int GW  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic [LEN-1:0] data;
    logic [7:0]     rule;
    logic [1:0]     bnd_mode;
    logic           start;
    logic [GW-1:0]  gens;
    logic           abort;
    logic           busy;
    logic           done;
    logic [GW-1:0]  gen_count;

    int vecs = 0;
    int errs = 0;

    eca_if #(.LEN(LEN)) bus ();

    eca_engine #(.LEN(LEN), .GW(GW)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data      (data),
        .rule      (rule),
        .bnd_mode  (bnd_mode),
        .start     (start),
        .gens      (gens),
        .abort     (abort),
        .out_if    (bus.master),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1;
        data = val;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] r, input logic [1:0] m, input logic [15:0] g);
        rule     = r;
        bnd_mode = m;
        gens     = g;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One-generation run with q_ready high: returns gen 1 and drains the done pulse
    task automatic one_gen(input string tag, input logic [7:0] r, input logic [1:0] m,
                           input logic [7:0] init, input logic [7:0] exp);
        do_load(init);
        bus.q_ready = 1'b1;
        do_start(r, m, 16'd1);
        chk({tag, "_q"}, bus.q, exp);
        tick();
        chk({tag, "_done"}, done, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load = 1'b0; data = '0; rule = '0; bnd_mode = '0;
        start = 1'b0; gens = '0; abort = 1'b0; bus.q_ready = 1'b0;
        tick();
        tick();
        chk("rst_q", bus.q, 0);
        chk("rst_valid", bus.q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gen", gen_count, 0);
        reset = 1'b0;

        // Rule 110, zero boundary, three generations back to back
        do_load(8'h01);
        bus.q_ready = 1'b1;
        do_start(8'd110, 2'd0, 16'd3);
        rule = 8'd0;
        bnd_mode = 2'd1;
        chk("r110_g1", bus.q, 8'h03);
        chk("r110_v1", bus.q_valid, 1);
        chk("r110_busy", busy, 1);
        tick();
        chk("r110_g2", bus.q, 8'h07);
        tick();
        chk("r110_g3", bus.q, 8'h0D);
        chk("r110_cnt3", gen_count, 3);
        chk("r110_nodone", done, 0);
        tick();
        chk("r110_done", done, 1);
        chk("r110_idle", busy, 0);
        chk("r110_valid0", bus.q_valid, 0);
        chk("r110_keep", bus.q, 8'h0D);
        chk("r110_cnt", gen_count, 3);
        tick();
        chk("r110_pulse", done, 0);

        one_gen("r90_wrap", 8'd90, 2'd2, 8'h01, 8'h82);
        one_gen("r90_zero", 8'd90, 2'd0, 8'h01, 8'h02);
        one_gen("r90_m3", 8'd90, 2'd3, 8'h01, 8'h02);
        one_gen("r110_one", 8'd110, 2'd1, 8'h00, 8'h01);

        // Rule 204 is the identity rule
        do_load(8'hA5);
        bus.q_ready = 1'b1;
        do_start(8'd204, 2'd0, 16'd4);
        for (int g = 1; g <= 4; g++) begin
            chk("r204_q", bus.q, 8'hA5);
            chk("r204_cnt", gen_count, g);
            tick();
        end
        chk("r204_done", done, 1);
        tick();

        // Backpressure holds gen 1 until q_ready rises
        do_load(8'h01);
        bus.q_ready = 1'b0;
        do_start(8'd110, 2'd0, 16'd2);
        for (int c = 0; c < 3; c++) begin
            chk("bp_q", bus.q, 8'h03);
            chk("bp_cnt", gen_count, 1);
            chk("bp_valid", bus.q_valid, 1);
            tick();
        end
        bus.q_ready = 1'b1;
        tick();
        chk("bp_g2", bus.q, 8'h07);
        chk("bp_cnt2", gen_count, 2);
        tick();
        chk("bp_done", done, 1);
        tick();

        // Abort at gen 2 of 5, with a concurrent handshake
        do_load(8'h01);
        bus.q_ready = 1'b1;
        do_start(8'd110, 2'd0, 16'd5);
        tick();
        chk("ab_g2", bus.q, 8'h07);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_cnt", gen_count, 2);
        chk("ab_q", bus.q, 8'h07);
        tick();
        chk("ab_done2", done, 0);

        // Load and start while busy are ignored
        do_load(8'hA5);
        bus.q_ready = 1'b0;
        do_start(8'd204, 2'd0, 16'd5);
        load = 1'b1; data = 8'hFF; start = 1'b1; gens = 16'd1;
        tick();
        load = 1'b0; start = 1'b0;
        chk("busy_ign_q", bus.q, 8'hA5);
        chk("busy_ign_cnt", gen_count, 1);
        chk("busy_ign_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Load wins over start in IDLE
        load = 1'b1; data = 8'h3C; start = 1'b1; gens = 16'd2; rule = 8'd110;
        tick();
        load = 1'b0; start = 1'b0;
        chk("ls_q", bus.q, 8'h3C);
        chk("ls_busy", busy, 0);
        chk("ls_cnt", gen_count, 0);

        // gens=0 start only pulses done
        do_start(8'd110, 2'd0, 16'd0);
        chk("g0_done", done, 1);
        chk("g0_busy", busy, 0);
        chk("g0_q", bus.q, 8'h3C);
        tick();
        chk("g0_pulse", done, 0);

        // Reset mid-run, then a normal run
        bus.q_ready = 1'b0;
        do_start(8'd110, 2'd0, 16'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_q", bus.q, 0);
        chk("mr_valid", bus.q_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cnt", gen_count, 0);
        one_gen("post_rst", 8'd110, 2'd0, 8'h01, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
